// File: rtl/csa_accumulator_pkg.sv
// Shared definitions for the carry-save accumulator: FSM state encoding
// and default term / accumulator widths.
package csa_accumulator_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_ACC_W = 32;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_RES_LO = 2'd1,
        ST_RES_HI = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

endpackage

// File: rtl/csa_accumulator_row.sv
// csa_row: W-wide row of independent 3:2 compressors.
// Ports: a, b, c (W) in; sum (W) = a^b^c, maj (W) = majority, unshifted.
module csa_row #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] maj
);

    for (genvar i = 0; i < W; i++) begin : g_csa_3_2
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        assign maj[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator: sums a stream of signed terms in carry-save form, then
// resolves the (S, C) pair with a two-cycle split carry-propagate adder.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_last
// input stream; out_valid/out_ready/out_data resolved sum (mod 2^ACC_W).
module csa_accumulator
    import csa_accumulator_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);

    localparam int H = ACC_W / 2;

    state_t state_q;
    state_t state_d;

    logic [ACC_W-1:0] s_q;
    logic [ACC_W-1:0] c_q;
    logic [H-1:0]     lo_q;
    logic             cy_q;

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] row_sum;
    logic [ACC_W-1:0] row_maj;
    logic [H:0]       lo_sum;
    logic [H-1:0]     hi_sum;

    // Sign-extend the term; written this way so ACC_W == IN_W stays legal.
    always_comb begin
        x = {ACC_W{in_data[IN_W-1]}};
        x[IN_W-1:0] = in_data;
    end

    csa_row #(.W(ACC_W)) u_row (
        .a   (s_q),
        .b   (c_q),
        .c   (x),
        .sum (row_sum),
        .maj (row_maj)
    );

    assign lo_sum = {1'b0, s_q[H-1:0]} + {1'b0, c_q[H-1:0]};
    assign hi_sum = s_q[ACC_W-1:H] + c_q[ACC_W-1:H]
                  + {{(H-1){1'b0}}, cy_q};

    assign in_ready = (state_q == ST_ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACCUM: begin
                if (in_valid && in_last) begin
                    state_d = ST_RES_LO;
                end
            end
            ST_RES_LO: state_d = ST_RES_HI;
            ST_RES_HI: state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q       <= '0;
            c_q       <= '0;
            lo_q      <= '0;
            cy_q      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (in_valid) begin
                        s_q <= row_sum;
                        // Full-width shift drops the MSB carry (mod 2^ACC_W).
                        c_q <= row_maj << 1;
                    end
                end
                ST_RES_LO: begin
                    {cy_q, lo_q} <= lo_sum;
                end
                ST_RES_HI: begin
                    out_data  <= {hi_sum, lo_q};
                    out_valid <= 1'b1;
                    s_q       <= '0;
                    c_q       <= '0;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
